// File: rtl/seg7_pkg.sv
// -----------------------------------------------------------------------------
// seg7_pkg
// Shared definitions for the multiplexed 7-segment display driver:
//   - glyph constants for a common-cathode display, bit order {g,f,e,d,c,b,a},
//     where 1 means the segment is lit
//   - conversion FSM state type
//   - bcd_to_seg(): BCD nibble to glyph. Nibbles above 9 decode to blank.
// -----------------------------------------------------------------------------
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_DASH  = 7'h40;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    FINISH
  } conv_state_t;

  function automatic logic [6:0] bcd_to_seg(input logic [3:0] nibble);
    logic [6:0] seg;
    case (nibble)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seg7_scan_driver_bin2bcd_seq.sv
// -----------------------------------------------------------------------------
// bin2bcd_seq
// Sequential binary-to-BCD converter. It uses the shift-and-add-3 method and
// processes one input bit per clock, MSB first.
//
// Ports:
//   clk       in   system clock
//   rst       in   synchronous, active-high reset
//   load      in   start strobe. It is only honoured in IDLE.
//   value_in  in   [DATA_WIDTH-1:0] unsigned binary value
//   busy      out  high while the shift phase runs
//   done      out  one-cycle pulse when a conversion completes
//   bcd       out  [4*NUM_DIGITS-1:0] BCD result, units digit in [3:0].
//                  It is held unchanged when the value overflows.
//   overflow  out  the last captured value was >= 10**NUM_DIGITS
//
// Timing: if load is sampled at edge E0, done is high after edge E0+DATA_WIDTH+1.
// The range check assumes DATA_WIDTH <= 64.
// -----------------------------------------------------------------------------
module bin2bcd_seq
  import seg7_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_DIGITS = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [DATA_WIDTH-1:0]   value_in,
  output logic                    busy,
  output logic                    done,
  output logic [4*NUM_DIGITS-1:0] bcd,
  output logic                    overflow
);

  localparam int         CNT_W = $clog2(DATA_WIDTH);
  localparam logic [63:0] LIMIT = 64'(10 ** NUM_DIGITS);

  conv_state_t             state;
  logic [CNT_W-1:0]        bit_cnt;
  logic                    ovf_pend;
  logic [DATA_WIDTH-1:0]   bin_sr;
  logic [4*NUM_DIGITS-1:0] work;
  logic [4*NUM_DIGITS-1:0] work_adj;

  // Pre-shift correction: any digit >= 5 would become >= 10 after doubling.
  always_comb begin
    work_adj = work;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (work[4*k +: 4] >= 4'd5) work_adj[4*k +: 4] = work[4*k +: 4] + 4'd3;
    end
  end

  // Control path
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      overflow <= 1'b0;
      bcd      <= '0;
      bit_cnt  <= '0;
      ovf_pend <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (load) begin
            state    <= SHIFT;
            busy     <= 1'b1;
            ovf_pend <= (64'(value_in) >= LIMIT);
            bit_cnt  <= CNT_W'(DATA_WIDTH - 1);
          end
        end
        SHIFT: begin
          if (bit_cnt == '0) begin
            state <= FINISH;
            busy  <= 1'b0;
          end else begin
            bit_cnt <= bit_cnt - 1'b1;
          end
        end
        FINISH: begin
          done     <= 1'b1;
          overflow <= ovf_pend;
          // An out-of-range result is truncated, so the previous digits are kept.
          if (!ovf_pend) bcd <= work;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Datapath: working registers carry no reset
  always_ff @(posedge clk) begin
    if (state == IDLE && load) begin
      bin_sr <= value_in;
      work   <= '0;
    end else if (state == SHIFT) begin
      bin_sr <= {bin_sr[DATA_WIDTH-2:0], 1'b0};
      work   <= {work_adj[4*NUM_DIGITS-2:0], bin_sr[DATA_WIDTH-1]};
    end
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// -----------------------------------------------------------------------------
// seg7_scan_driver
// Multi-digit common-cathode 7-segment driver. A binary value is loaded,
// converted to BCD sequentially, and the digits are time-multiplexed onto one
// shared segment bus. A one-hot digit enable selects the active digit.
//
// Ports:
//   clk       in   system clock
//   rst       in   synchronous, active-high reset
//   value_in  in   [DATA_WIDTH-1:0] unsigned value to display
//   load      in   single-cycle strobe. It is accepted only when idle.
//   busy      out  conversion in progress
//   done      out  one-cycle pulse when a conversion completes
//   overflow  out  last captured value was >= 10**NUM_DIGITS (dashes shown)
//   bcd_out   out  [4*NUM_DIGITS-1:0] displayed digits, units in [3:0]
//   seg_out   out  [6:0] segments {g,f,e,d,c,b,a}, 1 = lit
//   digit_en  out  [NUM_DIGITS-1:0] one-hot enable, bit 0 = units
//
// Build option SEG7_LEADING_ZERO_BLANK_EN: when it is defined, leading zero
// digits above the units digit are blanked. Overflow dashes take priority
// over blanking.
// -----------------------------------------------------------------------------
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_DIGITS = 3,
  parameter int SCAN_DIV   = 50000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_WIDTH-1:0]   value_in,
  input  logic                    load,
  output logic                    busy,
  output logic                    done,
  output logic                    overflow,
  output logic [4*NUM_DIGITS-1:0] bcd_out,
  output logic [6:0]              seg_out,
  output logic [NUM_DIGITS-1:0]   digit_en
);

  localparam int PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [PRE_W-1:0]      pre_cnt;
  logic [IDX_W-1:0]      scan_idx;
  logic [6:0]            glyph_next;
  logic [NUM_DIGITS-1:0] en_next;

  bin2bcd_seq #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_DIGITS (NUM_DIGITS)
  ) u_conv (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .value_in (value_in),
    .busy     (busy),
    .done     (done),
    .bcd      (bcd_out),
    .overflow (overflow)
  );

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  logic [NUM_DIGITS-1:0] lead_zero;

  // A digit is a leading zero when it and every digit above it are zero.
  always_comb begin
    logic zero_run;
    zero_run  = 1'b1;
    lead_zero = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      zero_run     = zero_run && (bcd_out[4*k +: 4] == 4'd0);
      lead_zero[k] = zero_run && (k != 0);
    end
  end
`endif

  // Glyph and enable for the digit currently selected by the scan index
  always_comb begin
    glyph_next = SEG_BLANK;
    en_next    = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (scan_idx == IDX_W'(k)) begin
        en_next[k] = 1'b1;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        if (lead_zero[k]) glyph_next = SEG_BLANK;
        else              glyph_next = bcd_to_seg(bcd_out[4*k +: 4]);
`else
        glyph_next = bcd_to_seg(bcd_out[4*k +: 4]);
`endif
      end
    end
    if (overflow) glyph_next = SEG_DASH;
  end

  // Scan prescaler/index; enable and segments registered together
  always_ff @(posedge clk) begin
    if (rst) begin
      pre_cnt  <= '0;
      scan_idx <= '0;
      digit_en <= NUM_DIGITS'(1);
      seg_out  <= SEG_0;
    end else begin
      if (pre_cnt == PRE_W'(SCAN_DIV - 1)) begin
        pre_cnt <= '0;
        if (scan_idx == IDX_W'(NUM_DIGITS - 1)) scan_idx <= '0;
        else                                    scan_idx <= scan_idx + 1'b1;
      end else begin
        pre_cnt <= pre_cnt + 1'b1;
      end
      digit_en <= en_next;
      seg_out  <= glyph_next;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
`timescale 1ns/1ps
module tb_seg7_scan_driver;
  localparam int DW  = 8;
  localparam int ND  = 3;
  localparam int ND2 = 2;
  localparam int SD  = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            load;
  logic [DW-1:0]   value_in;
  logic            busy, done, overflow;
  logic [4*ND-1:0] bcd_out;
  logic [6:0]      seg_out;
  logic [ND-1:0]   digit_en;
  logic            busy2, done2, overflow2;
  logic [4*ND2-1:0] bcd_out2;
  logic [6:0]      seg_out2;
  logic [ND2-1:0]  digit_en2;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int exp_val, exp_val2;
  bit exp_ovf, exp_ovf2;
  logic [6:0] glyph_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  seg7_scan_driver #(.DATA_WIDTH(DW), .NUM_DIGITS(ND), .SCAN_DIV(SD)) u_dut (
    .clk(clk), .rst(rst), .value_in(value_in), .load(load), .busy(busy),
    .done(done), .overflow(overflow), .bcd_out(bcd_out), .seg_out(seg_out),
    .digit_en(digit_en));

  seg7_scan_driver #(.DATA_WIDTH(DW), .NUM_DIGITS(ND2), .SCAN_DIV(SD)) u_dut2 (
    .clk(clk), .rst(rst), .value_in(value_in), .load(load), .busy(busy2),
    .done(done2), .overflow(overflow2), .bcd_out(bcd_out2), .seg_out(seg_out2),
    .digit_en(digit_en2));

  always #5 clk = ~clk;

  // Cycles since reset release; used to predict the scan position.
  always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int pow10(input int d);
    int p = 1;
    for (int i = 0; i < d; i++) p *= 10;
    return p;
  endfunction

  function automatic int to_bcd(input int val, input int nd);
    int r = 0;
    for (int k = 0; k < nd; k++) r += ((val / pow10(k)) % 10) << (4 * k);
    return r;
  endfunction

  function automatic logic [6:0] exp_seg(input int val, input bit ovf, input int d);
    if (ovf) return 7'h40;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    if (d > 0 && val < pow10(d)) return 7'h00;
`endif
    return glyph_tab[(val / pow10(d)) % 10];
  endfunction

  task automatic check_scan(input int n);
    int d, d2;
    repeat (n) begin
      @(posedge clk); #1;
      d  = (cyc == 0) ? 0 : ((cyc - 1) / SD) % ND;
      d2 = (cyc == 0) ? 0 : ((cyc - 1) / SD) % ND2;
      check_val("digit_en", digit_en, 1 << d);
      check_val("seg_out", seg_out, exp_seg(exp_val, exp_ovf, d));
      check_val("digit_en2", digit_en2, 1 << d2);
      check_val("seg_out2", seg_out2, exp_seg(exp_val2, exp_ovf2, d2));
    end
  endtask

  // Load v; optionally pulse a second load (inj_val) after edge inj_at.
  task automatic run_conv(input int v, input int inj_at, input int inj_val);
    int lat;
    bit got;
    @(negedge clk); value_in = DW'(v); load = 1'b1;
    @(posedge clk); #1; load = 1'b0;
    check_val("busy_after_load", busy, 1);
    lat = 0;
    got = 0;
    while (!got && lat < 20) begin
      if (lat == inj_at) begin value_in = DW'(inj_val); load = 1'b1; end
      @(posedge clk); #1; load = 1'b0; lat++;
      if (done) got = 1;
    end
    check_val("latency", lat, DW + 1);
    check_val("done2", done2, 1);
    check_val("busy_at_done", busy, 0);
    if (v < pow10(ND)) exp_val = v;
    exp_ovf = (v >= pow10(ND));
    if (v < pow10(ND2)) exp_val2 = v;
    exp_ovf2 = (v >= pow10(ND2));
    check_val("bcd_out", bcd_out, to_bcd(exp_val, ND));
    check_val("overflow", overflow, exp_ovf);
    check_val("bcd_out2", bcd_out2, to_bcd(exp_val2, ND2));
    check_val("overflow2", overflow2, exp_ovf2);
    @(posedge clk); #1;
    check_val("done_pulse", done, 0);
    check_val("busy_idle", busy, 0);
  endtask

  initial begin
    bit saw_done;
    rst = 1'b1; load = 1'b0; value_in = '0;
    exp_val = 0; exp_val2 = 0; exp_ovf = 0; exp_ovf2 = 0;
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_seg", seg_out, 7'h3F);
    check_val("rst_en", digit_en, 3'b001);
    check_val("rst_bcd", bcd_out, 12'h000);
    check_val("rst_busy", busy, 0);
    check_val("rst_done", done, 0);
    check_val("rst_ovf", overflow, 0);
    @(negedge clk); rst = 1'b0;
    check_scan(12);

    run_conv(150, -1, 0);   check_scan(12);
    run_conv(255, 3, 7);    check_scan(4);
    run_conv(7, -1, 0);     check_scan(12);
    run_conv(99, 8, 5);     check_scan(8);
    run_conv(100, -1, 0);   check_scan(8);
    run_conv(150, -1, 0);   check_scan(8);
    run_conv(42, -1, 0);    check_scan(8);
    run_conv(0, -1, 0);     check_scan(12);

    // Reset during the shift phase aborts the conversion.
    @(negedge clk); value_in = DW'(100); load = 1'b1;
    @(negedge clk); load = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check_val("abort_busy", busy, 0);
    check_val("abort_done", done, 0);
    check_val("abort_bcd", bcd_out, 12'h000);
    check_val("abort_en", digit_en, 3'b001);
    check_val("abort_seg", seg_out, 7'h3F);
    check_val("abort_ovf2", overflow2, 0);
    @(negedge clk); rst = 1'b0;
    exp_val = 0; exp_val2 = 0; exp_ovf = 0; exp_ovf2 = 0;
    saw_done = 0;
    repeat (15) begin
      @(posedge clk); #1;
      saw_done |= done | done2;
    end
    check_val("abort_no_done", saw_done, 0);
    check_scan(12);

    repeat (20) begin
      run_conv($urandom_range(0, 255), -1, 0);
      check_scan($urandom_range(4, 12));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
